// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the shared data memory port.
// Each access takes IDLE -> BUSY -> DONE; sizing, lane steering and load extension happen here.
module dm_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
    parameter logic        RESET_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_uns,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_uns,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic access_bad(input logic [1:0] size, input logic [31:0] addr);
        logic misalign_s;
        case (size)
            2'd0:    misalign_s = 1'b0;
            2'd1:    misalign_s = addr[0];
            2'd2:    misalign_s = (addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
        return misalign_s | (addr >= ADDR_LIMIT);
    endfunction

    function automatic logic [3:0] lane_byteen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be_s;
        case (size)
            2'd0:    be_s = 4'b0001 << off;
            2'd1:    be_s = 4'b0011 << off;
            2'd2:    be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
        return be_s;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd_s;
        case (size)
            2'd0:    wd_s = {4{wdata[7:0]}};
            2'd1:    wd_s = {2{wdata[15:0]}};
            default: wd_s = wdata;
        endcase
        return wd_s;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] sh_s;
        logic [31:0] res_s;
        sh_s = rdata >> {off, 3'b000};
        case (size)
            2'd0:    res_s = {{24{~uns & sh_s[7]}}, sh_s[7:0]};
            2'd1:    res_s = {{16{~uns & sh_s[15]}}, sh_s[15:0]};
            default: res_s = sh_s;
        endcase
        return res_s;
    endfunction

    logic [1:0]  state_r;
    logic        last_r;
    logic        gnt_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic        bad_r;

    logic        req_any_s;
    logic        sel_s;
    logic        sel_we_s;
    logic [1:0]  sel_size_s;
    logic        sel_uns_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_bad_s;
    logic [31:0] load_s;

    // Round-robin pick and request field mux for the master about to be granted
    always_comb begin
        req_any_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
            sel_s = ~last_r;
        end else begin
            sel_s = m1_req;
        end
        if (sel_s) begin
            sel_we_s    = m1_we;
            sel_size_s  = m1_size;
            sel_uns_s   = m1_uns;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_size_s  = m0_size;
            sel_uns_s   = m0_uns;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
        sel_bad_s = access_bad(sel_size_s, sel_addr_s);
        load_s    = load_extract(size_r, uns_r, m_data_addr[1:0], m_data_rdata);
    end

    // Sequencer state and the latched attributes of the granted access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            last_r  <= RESET_LAST;
            gnt_r   <= 1'b0;
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
            bad_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        state_r <= ST_BUSY;
                        last_r  <= sel_s;
                        gnt_r   <= sel_s;
                        we_r    <= sel_we_s;
                        size_r  <= sel_size_s;
                        uns_r   <= sel_uns_s;
                        bad_r   <= sel_bad_s;
                    end
                end
                ST_BUSY: state_r <= ST_DONE;
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Memory port is loaded at the grant edge so it is valid for exactly the BUSY cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_addr   <= 32'd0;
            m_data_wdata  <= 32'd0;
            m_data_byteen <= 4'b0000;
        end else if (state_r == ST_IDLE && req_any_s) begin
            m_data_addr   <= sel_addr_s;
            m_data_wdata  <= lane_wdata(sel_size_s, sel_wdata_s);
            m_data_byteen <= (sel_we_s && !sel_bad_s) ? lane_byteen(sel_size_s, sel_addr_s[1:0])
                                                      : 4'b0000;
        end else begin
            m_data_addr   <= 32'd0;
            m_data_wdata  <= 32'd0;
            m_data_byteen <= 4'b0000;
        end
    end

    // Completion pulse during DONE for the granted master
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end else if (state_r == ST_BUSY) begin
            m0_ack <= ~gnt_r;
            m1_ack <= gnt_r;
            m0_err <= ~gnt_r & bad_r;
            m1_err <= gnt_r & bad_r;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end
    end

    // Load capture at the end of BUSY; rejected loads leave the old value in place
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
        end else if (state_r == ST_BUSY && !we_r && !bad_r) begin
            if (gnt_r) begin
                m1_rdata <= load_s;
            end else begin
                m0_rdata <= load_s;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized self-checking bench for dm_arbiter with a byte-array reference memory.
module tb_dm_arbiter;

    localparam logic [31:0] LIMIT = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_uns, m0_ack, m0_err;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_uns, m1_ack, m1_err;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;

    dm_arbiter #(.ADDR_LIMIT(LIMIT), .RESET_LAST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_uns(m0_uns),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_uns(m1_uns),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return 32'(w) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    // Memory the DUT actually talks to
    logic [31:0] env_mem [4096];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 4096; w++) env_mem[w] <= init_word(w);
        end else begin
            for (int b = 0; b < 4; b++)
                if (m_data_byteen[b]) env_mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
        end
    end
    assign m_data_rdata = env_mem[m_data_addr[13:2]];

    // Reference model state
    logic [7:0]  ref_bytes [16384];
    logic        ref_last;
    logic [31:0] ref_rdata [2];
    logic        req_v [2];
    logic        f_we [2];
    logic [1:0]  f_size [2];
    logic        f_uns [2];
    logic [31:0] f_addr [2];
    logic [31:0] f_wdata [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        m0_req = req_v[0]; m0_we = f_we[0]; m0_size = f_size[0]; m0_uns = f_uns[0];
        m0_addr = f_addr[0]; m0_wdata = f_wdata[0];
        m1_req = req_v[1]; m1_we = f_we[1]; m1_size = f_size[1]; m1_uns = f_uns[1];
        m1_addr = f_addr[1]; m1_wdata = f_wdata[1];
    endtask

    task automatic set_f(input int g, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        f_we[g] = we; f_size[g] = size; f_uns[g] = uns; f_addr[g] = addr; f_wdata[g] = wdata;
    endtask

    task automatic rand_f(input int g);
        int r;
        logic [1:0] sz;
        logic [31:0] a;
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r = $urandom_range(0, 19);
        if (r == 0) a = LIMIT + 32'($urandom_range(0, 255));
        else        a = 32'h100 + 32'($urandom_range(0, 63));
        if (r > 4 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
        set_f(g, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    function automatic logic is_bad(input int g);
        if (f_size[g] == 2'd3) return 1'b1;
        if (f_addr[g] >= LIMIT) return 1'b1;
        return (f_addr[g] % (32'd1 << f_size[g])) != 32'd0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int b;
        b = int'(addr & 32'h0000_3FFC);
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    task automatic check_idle();
        check("idle_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("idle_be", {28'd0, m_data_byteen}, 32'd0);
        check("idle_addr", m_data_addr, 32'd0);
        check("idle_wdata", m_data_wdata, 32'd0);
    endtask

    task automatic check_busy(input int g);
        logic [3:0] be;
        logic [31:0] wd;
        int n;
        be = 4'b0000;
        n = 1 << f_size[g];
        if (f_we[g] && !is_bad(g))
            for (int i = 0; i < n; i++) be[int'(f_addr[g][1:0]) + i] = 1'b1;
        check("busy_addr", m_data_addr, f_addr[g]);
        check("busy_be", {28'd0, m_data_byteen}, {28'd0, be});
        if (f_size[g] != 2'd3) begin
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = f_wdata[g][8*(i % n) +: 8];
            check("busy_wdata", m_data_wdata, wd);
        end
        check("busy_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    endtask

    task automatic check_done(input int g);
        logic bad;
        logic [63:0] v;
        int n, a;
        bad = is_bad(g);
        n = 1 << f_size[g];
        a = int'(f_addr[g] & 32'h0000_3FFF);
        if (!bad) begin
            if (f_we[g]) begin
                for (int i = 0; i < n; i++) ref_bytes[a+i] = f_wdata[g][8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[a+i]) << (8*i));
                if (!f_uns[g] && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
                ref_rdata[g] = v[31:0];
            end
        end
        ref_last = 1'(g);
        check("done_ack", {30'd0, m1_ack, m0_ack}, (g == 1) ? 32'd2 : 32'd1);
        check("done_err", {30'd0, m1_err, m0_err}, bad ? ((g == 1) ? 32'd2 : 32'd1) : 32'd0);
        check("done_be", {28'd0, m_data_byteen}, 32'd0);
        check("m0_rdata", m0_rdata, ref_rdata[0]);
        check("m1_rdata", m1_rdata, ref_rdata[1]);
        if (f_addr[g] < LIMIT) check("mem_word", env_mem[f_addr[g][13:2]], ref_word(f_addr[g]));
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE with requests dropped
    task automatic run_round(input logic r0, input logic r1);
        int first;
        req_v[0] = r0; req_v[1] = r1;
        drive();
        first = (r0 && r1) ? (ref_last ? 0 : 1) : (r1 ? 1 : 0);
        @(negedge clk) check_busy(first);
        @(negedge clk) check_done(first);
        req_v[first] = 1'b0;
        drive();
        if (r0 && r1) begin
            @(negedge clk) check_idle();
            @(negedge clk) check_busy(1 - first);
            @(negedge clk) check_done(1 - first);
            req_v[1 - first] = 1'b0;
            drive();
        end
        @(negedge clk) check_idle();
    endtask

    initial begin
        int g;
        reset = 1'b1;
        mem_init = 1'b1;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        set_f(0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_f(1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drive();
        for (int w = 0; w < 4096; w++)
            for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = init_word(w) >> (8*b);
        ref_last = 1'b1;
        ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_ack", {28'd0, m1_err, m0_err, m1_ack, m0_ack}, 32'd0);
        check("rst_rdata0", m0_rdata, 32'd0);
        check("rst_rdata1", m1_rdata, 32'd0);
        check("rst_be", {28'd0, m_data_byteen}, 32'd0);
        check("rst_addr", m_data_addr, 32'd0);
        reset = 1'b0;

        // Tie straight after reset: m0 first
        set_f(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h1111_1111);
        set_f(1, 1'b1, 2'd0, 1'b0, 32'h205, 32'h0000_00A5);
        run_round(1'b1, 1'b1);

        // Word and sub-word stores/loads with extension
        set_f(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF); run_round(1'b1, 1'b0);
        set_f(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);         run_round(1'b1, 1'b0);
        check("word_load", m0_rdata, 32'hDEAD_BEEF);
        set_f(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80);        run_round(1'b1, 1'b0);
        set_f(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);         run_round(1'b1, 1'b0);
        check("byte_sext", m0_rdata, 32'hFFFF_FF80);
        set_f(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);         run_round(1'b1, 1'b0);
        check("byte_zext", m0_rdata, 32'h0000_0080);
        set_f(1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234);      run_round(1'b0, 1'b1);
        set_f(1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);         run_round(1'b0, 1'b1);

        // Rejected accesses
        set_f(0, 1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF);      run_round(1'b1, 1'b0);
        set_f(1, 1'b1, 2'd2, 1'b0, 32'h22, 32'h5555_AAAA); run_round(1'b0, 1'b1);
        set_f(0, 1'b1, 2'd3, 1'b0, 32'h30, 32'h7777_7777); run_round(1'b1, 1'b0);
        set_f(1, 1'b1, 2'd2, 1'b0, 32'h4000, 32'h1);       run_round(1'b0, 1'b1);
        set_f(1, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0);         run_round(1'b0, 1'b1);

        // Both held continuously: strict alternation
        rand_f(0); rand_f(1);
        req_v[0] = 1'b1; req_v[1] = 1'b1;
        drive();
        for (int k = 0; k < 6; k++) begin
            g = ref_last ? 0 : 1;
            @(negedge clk) check_busy(g);
            @(negedge clk) check_done(g);
            if (k >= 4) req_v[g] = 1'b0;
            else rand_f(g);
            drive();
            @(negedge clk) check_idle();
        end

        // m1 holds req through its ack: two transactions, no extra one
        set_f(1, 1'b1, 2'd2, 1'b0, 32'h60, 32'h0102_0304);
        req_v[1] = 1'b1;
        drive();
        @(negedge clk) check_busy(1);
        @(negedge clk) check_done(1);
        set_f(1, 1'b0, 2'd0, 1'b0, 32'h63, 32'h0);
        drive();
        @(negedge clk) check_idle();
        @(negedge clk) check_busy(1);
        @(negedge clk) check_done(1);
        req_v[1] = 1'b0;
        drive();
        repeat (3) @(negedge clk) check_idle();

        // Reset while a store is in BUSY
        set_f(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D);
        req_v[0] = 1'b1;
        drive();
        @(negedge clk) check_busy(0);
        #2 reset = 1'b1;
        #1 check("rst_mid_be", {28'd0, m_data_byteen}, 32'd0);
        @(negedge clk);
        check("rst_mid_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("rst_mid_mem", env_mem[32'h40 >> 2], ref_word(32'h40));
        req_v[0] = 1'b0;
        drive();
        ref_last = 1'b1;
        ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
        @(negedge clk) reset = 1'b0;
        set_f(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        set_f(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        run_round(1'b1, 1'b1);

        // Random traffic
        for (int k = 0; k < 200; k++) begin
            int sel;
            sel = $urandom_range(1, 3);
            rand_f(0); rand_f(1);
            run_round(sel[0], sel[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter and access sequencer for the shared byte-enabled data memory port. It sits between the CPU load/store stage (master 0) and a secondary master such as a debug/DMA engine (master 1), and drives the `m_data_*` memory port. It grants the port round-robin, turns sized accesses into byte enables with lane-replicated write data, and extracts and extends read data. It also rejects misaligned, oversized-range and illegal-size accesses without touching memory.

## Interface
- `ADDR_LIMIT`, default 32'h0000_4000: first illegal byte address (4096 words); any access with addr >= limit is an error.
- `RESET_LAST`, default 1: value of the last-served pointer after reset, so master 0 wins the first tie.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  input  1  request; held high, with fields stable, until that master's ack.
- `m0_we`, `m1_we`  input  1  1 = store, 0 = load.
- `m0_size`, `m1_size`  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `m0_uns`, `m1_uns`  input  1  load zero-extends when 1, sign-extends when 0.
- `m0_addr`, `m1_addr`  input  32  byte address.
- `m0_wdata`, `m1_wdata`  input  32  store data, right-aligned.
- `m0_ack`, `m1_ack`  output  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  output  1  valid with ack; 1 = access rejected.
- `m0_rdata`, `m1_rdata`  output  32  load result; registered, holds until that master's next load ack.
- `m_data_addr`  output  32  memory byte address; unmasked, memory ignores bits [1:0].
- `m_data_wdata`  output  32  lane-replicated write data.
- `m_data_byteen`  output  4  byte write enables; nonzero only in BUSY for a legal store.
- `m_data_rdata`  input  32  combinational memory read word for `m_data_addr`.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **Reset values:** IDLE; all outputs 0; `last` = RESET_LAST.
- **IDLE, no request:** if no req is high, stay in IDLE.
- **IDLE, one request:** grant that master.
- **IDLE, both requesting:** grant the master not equal to `last`.
- **On grant:**
  - Latch we, size, uns, addr and wdata.
  - Set `last` to the granted index.
  - Compute `bad` = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (addr >= ADDR_LIMIT).
  - Go to BUSY.
- **BUSY:** lasts exactly one cycle. Drive `m_data_addr` = latched addr and `m_data_wdata` by size:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- **BUSY byte enables:** `m_data_byteen`, with off = addr[1:0]:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
  - 0 if the access is a load or `bad`.
- **BUSY load capture:** at the BUSY edge, capture the lane from `m_data_rdata` into the granted master's rdata:
  - byte: rdata[8*off+7 : 8*off]
  - half: rdata[8*off+15 : 8*off]
  - word: full word
  - Extend by uns. No capture when `bad` (rdata keeps its old value).
- **DONE:**
  - Granted master's ack = 1; err = `bad`.
  - Memory outputs 0.
  - Requests are not sampled.
  - Next state IDLE.
- **Outside BUSY:** `m_data_addr`, `m_data_wdata` and `m_data_byteen` are 0.

## Timing
- Latency is fixed: req seen in IDLE at edge N, BUSY during N..N+1, ack high during N+1..N+2.
- Peak throughput is one access per 3 cycles.
- The memory write commits at the edge ending BUSY.
- The requester must drop req, or present a new request, in the ack cycle. Req is sampled again only in IDLE, so a req held through DONE counts as a new request.
- Both masters requesting continuously alternate 0,1,0,1...
- Req rising while the other master is in BUSY/DONE waits. It is granted in the next IDLE, subject to round-robin.
- **Reset mid-operation** (asynchronous):
  - State goes to IDLE and `m_data_byteen` drops to 0 immediately, so no write occurs.
  - No ack is produced; `last` = RESET_LAST.
- An error access spends the same 3 cycles as a legal one. Memory is never written on error.

## Test plan
- **Word store/load, m0:** store addr 0x10, wdata 0xDEADBEEF, size 2 -> byteen 4'b1111 in BUSY, ack one cycle later, err 0. Then load 0x10 -> m0_rdata 0xDEADBEEF.
- **Sub-word with extension:** store byte 0x80 at 0x13 -> byteen 4'b1000, wdata 0x80808080.
  - Load byte 0x13 with uns=0 -> 0xFFFFFF80; with uns=1 -> 0x00000080.
  - Store half 0x1234 at 0x22 -> byteen 4'b1100.
- **Simultaneous requests after reset:** both req at the same edge -> m0 granted first, then m1. Held continuously -> grants alternate 0,1,0,1 with 3-cycle spacing.
- **Errors, no memory write:** each of the following gives ack with err=1, byteen stays 0 and memory is unchanged:
  - half at 0x21
  - word at 0x22
  - size 3
  - word at 0x4000
- **Reset during BUSY:** assert reset mid-cycle while a store to 0x40 is in BUSY -> byteen 0 at once, word 0x40 unchanged, no ack. After release, the first tie goes to m0.
- **Req held through ack:** m1 keeps req high for two transactions -> exactly two acks, 3 cycles apart, with no extra BUSY.
